// File: rtl/tge_snap_pkg.sv
// Shared definitions for the 10GbE TX snapshot capture controller:
// FSM state encoding plus bit positions in the control and status words.
package tge_snap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_OFFSET  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } snap_state_e;

  // Control word bit positions
  localparam int CTRL_ARM          = 0;
  localparam int CTRL_TRIG_IMM     = 1;
  localparam int CTRL_VALID_ALWAYS = 2;
  localparam int CTRL_OFFSET_LSB   = 16;
  localparam int CTRL_OFFSET_MSB   = 31;

  // Status word bit positions
  localparam int STAT_DONE = 31;
  localparam int STAT_BUSY = 30;

endpackage

// File: rtl/tge_snap_ctrl.sv
// Snapshot capture controller: arms on a rising edge of ctrl[0], waits for a
// qualified trigger, optionally skips a post-trigger offset, then writes
// 2^ADDR_W qualified samples into the snapshot BRAM with one cycle latency.
module tge_snap_ctrl
  import tge_snap_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 11
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       ctrl,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              trig,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  output logic [31:0]       status
);

  // Full capture length; count_q is one bit wider so it can hold this value.
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  snap_state_e       state_q;
  logic              arm_q;
  logic [15:0]       off_cnt_q;
  logic [ADDR_W:0]   count_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic        arm_edge;
  logic        qual;
  logic        trig_hit;
  logic [15:0] offset;
  logic        do_write;

  // ctrl[15:3] carries nothing for this block.
  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^ctrl[15:3];

  assign arm_edge = ctrl[CTRL_ARM] & ~arm_q;
  assign qual     = din_valid | ctrl[CTRL_VALID_ALWAYS];
  assign trig_hit = trig | ctrl[CTRL_TRIG_IMM];
  assign offset   = ctrl[CTRL_OFFSET_MSB:CTRL_OFFSET_LSB];

  // Decide whether this cycle's sample goes to the BRAM; an arm edge always
  // wins, so the sample coincident with it is dropped.
  always_comb begin
    do_write = 1'b0;
    if (!arm_edge && qual) begin
      unique case (state_q)
        ST_ARMED:   do_write = trig_hit && (offset == 16'd0);
        ST_OFFSET:  do_write = (off_cnt_q == 16'd1);
        ST_CAPTURE: do_write = (count_q != DEPTH);
        default:    do_write = 1'b0;
      endcase
    end
  end

  // Control FSM: arm edge detect, trigger/offset sequencing and completion.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q   <= ST_IDLE;
      arm_q     <= 1'b1;   // a level already high at reset release must not arm
      off_cnt_q <= 16'd0;
    end else begin
      arm_q <= ctrl[CTRL_ARM];
      if (arm_edge) begin
        state_q   <= ST_ARMED;
        off_cnt_q <= 16'd0;
      end else begin
        unique case (state_q)
          ST_ARMED: begin
            if (qual && trig_hit) begin
              if (offset == 16'd0) begin
                state_q <= ST_CAPTURE;
              end else begin
                // Trigger sample is index 0; index K is the first one stored.
                off_cnt_q <= offset;
                state_q   <= ST_OFFSET;
              end
            end
          end
          ST_OFFSET: begin
            if (qual) begin
              off_cnt_q <= off_cnt_q - 16'd1;
              if (off_cnt_q == 16'd1) begin
                state_q <= ST_CAPTURE;
              end
            end
          end
          ST_CAPTURE: begin
            // Leave one cycle after the final write so done follows bram_we.
            if (count_q == DEPTH) begin
              state_q <= ST_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Write datapath: registered BRAM port and the words-written counter,
  // which also serves as the next write address.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      we_q <= 1'b0;
      if (arm_edge) begin
        count_q <= '0;
      end else if (do_write) begin
        we_q    <= 1'b1;
        addr_q  <= count_q[ADDR_W-1:0];
        data_q  <= din;
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign bram_we   = we_q;
  assign bram_addr = addr_q;
  assign bram_din  = data_q;

  // Status word decode from registered state and count.
  always_comb begin
    status             = '0;
    status[STAT_DONE]  = (state_q == ST_DONE);
    status[STAT_BUSY]  = (state_q == ST_ARMED) || (state_q == ST_OFFSET) ||
                         (state_q == ST_CAPTURE);
    status[ADDR_W:0]   = count_q;
  end

endmodule

// File: tb/tb_tge_snap_ctrl.sv
// Self-checking bench for tge_snap_ctrl with ADDR_W=4 (16-word captures).
// Expected BRAM writes are queued while stimulus is driven and matched
// cycle-accurately against bram_we/bram_addr/bram_din on the falling edge.
module tb_tge_snap_ctrl;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              user_clk = 1'b0;
  logic              user_rst;
  logic [31:0]       ctrl;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              trig;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              bram_we;
  logic [31:0]       status;

  tge_snap_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .user_clk  (user_clk),
    .user_rst  (user_rst),
    .ctrl      (ctrl),
    .din       (din),
    .din_valid (din_valid),
    .trig      (trig),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .bram_we   (bram_we),
    .status    (status)
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  exp_t              sb_q[$];
  int                cyc = 0;
  int                n_checks = 0;
  int                n_pass = 0;
  int                w_idx = 0;
  logic [DATA_W-1:0] ramp = 64'h1000;
  bit                mon_en = 1'b0;

  always @(posedge user_clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
  endtask

  // Scoreboard: a write is expected exactly in the cycle stamped at push time.
  always @(negedge user_clk) begin
    if (mon_en) begin
      bit   exp_we;
      exp_t e;
      exp_we = (sb_q.size() > 0) && (sb_q[0].cyc == cyc);
      check_val("bram_we", {63'd0, bram_we}, {63'd0, exp_we});
      if (exp_we) begin
        e = sb_q.pop_front();
        if (bram_we) begin
          check_val("bram_addr", {60'd0, bram_addr}, {60'd0, e.addr});
          check_val("bram_din", bram_din, e.data);
          $display("write addr=%0d data=%h cyc=%0d", bram_addr, bram_din, cyc);
        end
      end else if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        e = sb_q.pop_front();
      end
    end
  end

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  // Drive one cycle of stimulus; if a write is expected, it appears next cycle.
  task automatic run_cycle(input logic [31:0] c, input logic v, input logic t, input bit exp_wr);
    exp_t e;
    ctrl      = c;
    din_valid = v;
    trig      = t;
    din       = ramp;
    if (exp_wr) begin
      e.addr = w_idx[ADDR_W-1:0];
      e.data = ramp;
      e.cyc  = cyc + 1;
      sb_q.push_back(e);
      w_idx++;
    end
    ramp = ramp + 1;
    tick();
  endtask

  initial begin
    user_rst  = 1'b1;
    ctrl      = 32'h1;
    din       = '0;
    din_valid = 1'b0;
    trig      = 1'b0;

    // Reset state, with arm level held high through reset
    tick();
    mon_en = 1'b1;
    tick();
    tick();
    check_val("rst_status", {32'd0, status}, 64'd0);
    check_val("rst_addr", {60'd0, bram_addr}, 64'd0);
    check_val("rst_din", bram_din, 64'd0);
    user_rst = 1'b0;
    for (int i = 0; i < 3; i++) run_cycle(32'h1, 1'b0, 1'b0, 1'b0);
    check_val("no_arm_at_rst", {32'd0, status}, 64'd0);
    run_cycle(32'h0, 1'b0, 1'b0, 1'b0);
    run_cycle(32'h1, 1'b0, 1'b0, 1'b0);
    check_val("arm_busy", {32'd0, status}, 64'h4000_0000);

    // External trigger pulse, offset 0, continuous valid ramp
    w_idx = 0;
    for (int i = 0; i < 25; i++)
      run_cycle(32'h1, 1'b1, (i == 3), (i >= 3) && (w_idx < DEPTH));
    check_val("t1_status", {32'd0, status}, 64'h8000_0010);

    // Offset 3, immediate trigger: first stored word is trigger value + 3
    run_cycle(32'h0, 1'b1, 1'b0, 1'b0);
    w_idx = 0;
    run_cycle(32'h0003_0003, 1'b1, 1'b0, 1'b0);
    check_val("t2_armed", {32'd0, status}, 64'h4000_0000);
    for (int j = 0; j < 22; j++)
      run_cycle(32'h0003_0003, 1'b1, 1'b0, (j >= 3) && (w_idx < DEPTH));
    check_val("t2_status", {32'd0, status}, 64'h8000_0010);

    // valid_always: every cycle written even when din_valid toggles
    run_cycle(32'h0, 1'b0, 1'b0, 1'b0);
    w_idx = 0;
    run_cycle(32'h5, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 20; j++)
      run_cycle(32'h5, (j % 2 == 0), 1'b1, (w_idx < DEPTH));
    check_val("t3a_status", {32'd0, status}, 64'h8000_0010);

    // valid qualified: only valid cycles written, gaps leave bram_we low
    run_cycle(32'h0, 1'b0, 1'b0, 1'b0);
    w_idx = 0;
    run_cycle(32'h1, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 40; j++) begin
      logic v;
      v = (j % 2 == 1);
      run_cycle(32'h1, v, 1'b1, v && (w_idx < DEPTH));
    end
    check_val("t3b_status", {32'd0, status}, 64'h8000_0010);

    // Re-arm mid-capture after 7 writes
    run_cycle(32'h0, 1'b1, 1'b0, 1'b0);
    w_idx = 0;
    run_cycle(32'h1, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 7; j++)
      run_cycle((j >= 5) ? 32'h0 : 32'h1, 1'b1, (j == 0), 1'b1);
    check_val("t4_mid_count", {32'd0, status}, 64'h4000_0007);
    run_cycle(32'h1, 1'b1, 1'b0, 1'b0);
    check_val("t4_rearm", {32'd0, status}, 64'h4000_0000);
    w_idx = 0;
    run_cycle(32'h1, 1'b1, 1'b0, 1'b0);
    run_cycle(32'h1, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 18; j++)
      run_cycle(32'h1, 1'b1, (j == 0), (w_idx < DEPTH));
    check_val("t4_status", {32'd0, status}, 64'h8000_0010);

    // Arm edge and trigger in the same cycle from IDLE
    user_rst = 1'b1;
    run_cycle(32'h0, 1'b0, 1'b0, 1'b0);
    run_cycle(32'h0, 1'b0, 1'b0, 1'b0);
    user_rst = 1'b0;
    run_cycle(32'h0, 1'b0, 1'b0, 1'b0);
    check_val("t6_idle", {32'd0, status}, 64'd0);
    w_idx = 0;
    run_cycle(32'h1, 1'b1, 1'b1, 1'b0);
    check_val("t6_armed", {32'd0, status}, 64'h4000_0000);
    for (int j = 0; j < 18; j++)
      run_cycle(32'h1, 1'b1, (j == 0), (w_idx < DEPTH));
    check_val("t6_status", {32'd0, status}, 64'h8000_0010);

    for (int i = 0; i < 3; i++) run_cycle(32'h1, 1'b1, 1'b1, 1'b0);
    check_val("done_holds", {32'd0, status}, 64'h8000_0010);
    check_val("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
